// File: rtl/decode_writeback.sv
// SEQ Y86-64 decode/write-back stage: register file, sticky status and retired-instruction counter.
// Optional macro RSP_INIT_EN: reset loads %rsp with STACK_TOP instead of zero.
module decode_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        Cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        imem_error,
    input  logic        instr_valid,
    input  logic        dmem_error,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [2:0]  stat,
    output logic [63:0] retired
);

    localparam int unsigned NumRegs = 15;

    localparam logic [3:0] RegRsp  = 4'h4;
    localparam logic [3:0] RegNone = 4'hF;

    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatHlt = 3'd2;
    localparam logic [2:0] StatAdr = 3'd3;
    localparam logic [2:0] StatIns = 3'd4;

    localparam logic [3:0] IHalt   = 4'h0;
    localparam logic [3:0] IRrmovq = 4'h2;
    localparam logic [3:0] IIrmovq = 4'h3;
    localparam logic [3:0] IRmmovq = 4'h4;
    localparam logic [3:0] IMrmovq = 4'h5;
    localparam logic [3:0] IOpq    = 4'h6;
    localparam logic [3:0] ICall   = 4'h8;
    localparam logic [3:0] IRet    = 4'h9;
    localparam logic [3:0] IPushq  = 4'hA;
    localparam logic [3:0] IPopq   = 4'hB;

`ifdef RSP_INIT_EN
    localparam logic [63:0] STACK_TOP = 64'h0000_0000_0000_0200;
    localparam logic [63:0] RspReset  = STACK_TOP;
`else
    localparam logic [63:0] RspReset  = 64'h0;
`endif

    logic [63:0] regs_q [NumRegs];
    logic [2:0]  stat_q;
    logic [63:0] retired_q;

    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic [2:0] cur_stat;
    logic       commit;

    always_comb begin
        src_a = RegNone;
        src_b = RegNone;
        dst_e = RegNone;
        dst_m = RegNone;
        unique case (icode)
            IRrmovq: begin
                src_a = rA;
                dst_e = Cnd ? rB : RegNone;
            end
            IIrmovq: dst_e = rB;
            IRmmovq: begin
                src_a = rA;
                src_b = rB;
            end
            IMrmovq: begin
                src_b = rB;
                dst_m = rA;
            end
            IOpq: begin
                src_a = rA;
                src_b = rB;
                dst_e = rB;
            end
            ICall: begin
                src_b = RegRsp;
                dst_e = RegRsp;
            end
            IRet: begin
                src_a = RegRsp;
                src_b = RegRsp;
                dst_e = RegRsp;
            end
            IPushq: begin
                src_a = rA;
                src_b = RegRsp;
                dst_e = RegRsp;
            end
            IPopq: begin
                src_a = RegRsp;
                src_b = RegRsp;
                dst_e = RegRsp;
                dst_m = rA;
            end
            default: ;
        endcase
    end

    always_comb begin
        if (imem_error || dmem_error) begin
            cur_stat = StatAdr;
        end else if (!instr_valid) begin
            cur_stat = StatIns;
        end else if (icode == IHalt) begin
            cur_stat = StatHlt;
        end else begin
            cur_stat = StatAok;
        end
    end

    assign commit = (stat_q == StatAok) && (cur_stat == StatAok);

    // Index F never matches an entry, so reads of F return 0 and writes to F vanish.
    always_comb begin
        valA = '0;
        valB = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (src_a == 4'(i)) valA = regs_q[i];
            if (src_b == 4'(i)) valB = regs_q[i];
        end
    end

    // valM is checked first so popq %rsp stores the popped value, not the bumped pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= (i == int'(RegRsp)) ? RspReset : 64'h0;
            end
        end else if (commit) begin
            for (int i = 0; i < NumRegs; i++) begin
                if (dst_m == 4'(i)) begin
                    regs_q[i] <= valM;
                end else if (dst_e == 4'(i)) begin
                    regs_q[i] <= valE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_q    <= StatAok;
            retired_q <= '0;
        end else if (stat_q == StatAok) begin
            stat_q <= cur_stat;
            if (commit) begin
                retired_q <= retired_q + 64'd1;
            end
        end
    end

    assign stat    = stat_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback: stimulus queues expected outputs, a negedge monitor checks them.
module tb_decode_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        Cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        imem_error;
    logic        instr_valid;
    logic        dmem_error;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [2:0]  stat;
    logic [63:0] retired;

`ifdef RSP_INIT_EN
    localparam logic [63:0] RspExp = 64'h200;
`else
    localparam logic [63:0] RspExp = 64'h0;
`endif

    typedef struct {
        string       tag;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  st;
        logic [63:0] ret;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    decode_writeback dut (
        .clk        (clk),
        .reset      (reset),
        .icode      (icode),
        .rA         (rA),
        .rB         (rB),
        .Cnd        (Cnd),
        .valE       (valE),
        .valM       (valM),
        .imem_error (imem_error),
        .instr_valid(instr_valid),
        .dmem_error (dmem_error),
        .valA       (valA),
        .valB       (valB),
        .stat       (stat),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic drv(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic cnd, input logic [63:0] ve, input logic [63:0] vm,
                       input logic ie, input logic iv, input logic de);
        icode       = ic;
        rA          = ra;
        rB          = rb;
        Cnd         = cnd;
        valE        = ve;
        valM        = vm;
        imem_error  = ie;
        instr_valid = iv;
        dmem_error  = de;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [63:0] a, input logic [63:0] b,
                              input logic [2:0] st, input logic [63:0] ret);
        exp_t e;
        e.tag = tag;
        e.a   = a;
        e.b   = b;
        e.st  = st;
        e.ret = ret;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drv(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (valA !== e.a) begin
                failures++;
                $display("FAIL %s valA got %h want %h", e.tag, valA, e.a);
            end
            checks++;
            if (valB !== e.b) begin
                failures++;
                $display("FAIL %s valB got %h want %h", e.tag, valB, e.b);
            end
            checks++;
            if (stat !== e.st) begin
                failures++;
                $display("FAIL %s stat got %0d want %0d", e.tag, stat, e.st);
            end
            checks++;
            if (retired !== e.ret) begin
                failures++;
                $display("FAIL %s retired got %0d want %0d", e.tag, retired, e.ret);
            end
        end
    end

    initial begin
        reset = 1'b1;
        drv(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        // Probe while still in reset: nothing commits at this edge.
        drv(4'h4, 4'h1, 4'h4, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("reset_state", 64'h0, RspExp, 3'd1, 64'd0);
        tick();
        reset = 1'b0;

        // irmovq $0x2A, r2
        drv(4'h3, 4'hF, 4'h2, 1'b0, 64'h2A, 64'h0, 1'b0, 1'b1, 1'b0);
        tick();
        drv(4'h6, 4'hF, 4'h2, 1'b0, 64'h2A, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("irmovq", 64'h0, 64'h2A, 3'd1, 64'd1);
        tick();

        // cmov not taken, then taken
        drv(4'h2, 4'h1, 4'h3, 1'b0, 64'h55, 64'h0, 1'b0, 1'b1, 1'b0);
        tick();
        drv(4'h4, 4'h3, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("cmov_cnd0", 64'h0, 64'h0, 3'd1, 64'd3);
        tick();
        drv(4'h2, 4'h1, 4'h3, 1'b1, 64'h55, 64'h0, 1'b0, 1'b1, 1'b0);
        tick();
        drv(4'h4, 4'h3, 4'h2, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("cmov_cnd1", 64'h55, 64'h2A, 3'd1, 64'd5);
        tick();

        // popq %rsp: valM must win over valE
        drv(4'hB, 4'h4, 4'hF, 1'b0, 64'h208, 64'hDEAD, 1'b0, 1'b1, 1'b0);
        tick();
        drv(4'h4, 4'h4, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("popq_rsp", 64'hDEAD, 64'h0, 3'd1, 64'd7);
        tick();

        // pushq r2: only %rsp written with valE
        drv(4'hA, 4'h2, 4'hF, 1'b0, 64'h1F8, 64'h0, 1'b0, 1'b1, 1'b0);
        tick();
        drv(4'h4, 4'h4, 4'h3, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("pushq", 64'h1F8, 64'h55, 3'd1, 64'd9);
        tick();

        // popq r7: both ports write different registers
        drv(4'hB, 4'h7, 4'hF, 1'b0, 64'h200, 64'hBEEF, 1'b0, 1'b1, 1'b0);
        tick();
        drv(4'h4, 4'h7, 4'h4, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("popq_r7", 64'hBEEF, 64'h200, 3'd1, 64'd11);
        tick();

        // mrmovq to r8, irmovq to top register r14
        drv(4'h5, 4'h8, 4'h2, 1'b0, 64'h30, 64'h77, 1'b0, 1'b1, 1'b0);
        tick();
        drv(4'h4, 4'h8, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("mrmovq", 64'h77, 64'h0, 3'd1, 64'd13);
        tick();
        drv(4'h3, 4'hF, 4'hE, 1'b0, 64'hEE, 64'h0, 1'b0, 1'b1, 1'b0);
        tick();
        drv(4'h4, 4'hE, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("r14", 64'hEE, 64'h0, 3'd1, 64'd15);
        tick();

        // OPq r9,r9: reads see old value until the edge
        drv(4'h6, 4'h9, 4'h9, 1'b0, 64'h99, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("no_bypass", 64'h0, 64'h0, 3'd1, 64'd16);
        tick();
        drv(4'h4, 4'h9, 4'h9, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("opq_write", 64'h99, 64'h99, 3'd1, 64'd17);
        tick();

        // halt, then a would-be write is blocked
        drv(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        tick();
        drv(4'h3, 4'hF, 4'h5, 1'b0, 64'h7, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("halt", 64'h0, 64'h0, 3'd2, 64'd18);
        tick();
        drv(4'h4, 4'h5, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("halt_sticky", 64'h0, 64'h0, 3'd2, 64'd18);
        tick();

        // async reset mid-cycle after r1 = 0x11
        do_reset();
        drv(4'h3, 4'hF, 4'h1, 1'b0, 64'h11, 64'h0, 1'b0, 1'b1, 1'b0);
        tick();
        drv(4'h4, 4'h1, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("r1_set", 64'h11, 64'h0, 3'd1, 64'd1);
        tick();
        drv(4'h2, 4'h1, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        expect_out("async_reset", 64'h0, 64'h0, 3'd1, 64'd0);
        tick();
        drv(4'h8, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("reset_rsp", 64'h0, RspExp, 3'd1, 64'd0);
        tick();
        reset = 1'b0;

        // imem_error with instr_valid low: ADR beats INS
        drv(4'h3, 4'hF, 4'h2, 1'b0, 64'h5, 64'h0, 1'b1, 1'b0, 1'b0);
        tick();
        drv(4'h4, 4'h2, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("imem_adr", 64'h0, 64'h0, 3'd3, 64'd0);
        tick();

        // dmem_error on mrmovq r6
        do_reset();
        drv(4'h5, 4'h6, 4'hF, 1'b0, 64'h0, 64'h9, 1'b0, 1'b1, 1'b1);
        tick();
        drv(4'h4, 4'h6, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("dmem_adr", 64'h0, 64'h0, 3'd3, 64'd0);
        tick();

        // illegal instruction
        do_reset();
        drv(4'h3, 4'hF, 4'h2, 1'b0, 64'h1, 64'h0, 1'b0, 1'b0, 1'b0);
        tick();
        drv(4'h4, 4'h2, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("ins", 64'h0, 64'h0, 3'd4, 64'd0);
        tick();

        // halt icode with dmem_error: ADR beats HLT
        do_reset();
        drv(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1);
        tick();
        drv(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        expect_out("adr_over_hlt", 64'h0, 64'h0, 3'd3, 64'd0);
        tick();

        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
